// File: rtl/req_arbiter_8.sv
// req_arbiter_8 -- eight-requester arbiter for one shared downstream resource.
//
// A winner is chosen in IDLE, either by fixed priority (bit 7 highest) or by
// round-robin starting below the last granted index. The grant is registered
// and held until the owner releases it, the owner drops its request, or the
// hold limit expires. Every grant is followed by at least one IDLE cycle,
// which is the arbitration cycle.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset
//   req[7:0]  in   level-sensitive request vector, bit i = requester i
//   rel       in   release strobe from the current owner (ignored in IDLE)
//   rr_mode   in   0 = fixed priority, 1 = round-robin; sampled in IDLE only
//   gnt[7:0]  out  registered one-hot grant, zero when no grant is active
//   gnt_id    out  encoded index of the owner, zero when gnt_valid = 0
//   gnt_valid out  high while a grant is active
//   timeout   out  one-cycle pulse after a grant is revoked by the hold limit

module req_arbiter_8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       rel,
  input  logic       rr_mode,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam int unsigned CW = $clog2(MAX_HOLD);

  typedef enum logic [0:0] {
    StIdle,
    StGrant
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      gnt_q, gnt_d;
  logic [2:0]      gnt_id_q, gnt_id_d;
  logic            gnt_valid_q, gnt_valid_d;
  logic            timeout_q, timeout_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      last_id_q, last_id_d;

  logic [2:0]      fp_id;
  logic [2:0]      rr_id;
  logic [2:0]      win_id;
  logic            any_req;
  logic            owner_req;
  logic            hold_hit;
  logic            grant_end;

  // Fixed priority: ascending scan, so the highest set bit is the last to land.
  always_comb begin
    fp_id = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (req[i]) begin
        fp_id = 3'(i);
      end
    end
  end

  // Round-robin: scan last_id-1, last_id-2, ... wrapping modulo 8, ending at
  // last_id itself so the previous winner has the lowest priority.
  always_comb begin
    logic       found;
    logic [2:0] idx;
    rr_id = 3'd0;
    found = 1'b0;
    idx   = 3'd0;
    for (int k = 1; k <= 8; k++) begin
      idx = last_id_q - 3'(k);
      if (!found && req[idx]) begin
        rr_id = idx;
        found = 1'b1;
      end
    end
  end

  assign any_req   = |req;
  assign win_id    = rr_mode ? rr_id : fp_id;
  assign owner_req = req[gnt_id_q];
  assign hold_hit  = (cnt_q == CW'(MAX_HOLD - 1));
  assign grant_end = rel | ~owner_req | hold_hit;

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;
    cnt_d       = cnt_q;
    last_id_d   = last_id_q;

    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          state_d     = StGrant;
          gnt_d       = 8'd1 << win_id;
          gnt_id_d    = win_id;
          gnt_valid_d = 1'b1;
          cnt_d       = '0;
          last_id_d   = win_id;
        end
      end
      StGrant: begin
        if (grant_end) begin
          state_d     = StIdle;
          gnt_d       = 8'd0;
          gnt_id_d    = 3'd0;
          gnt_valid_d = 1'b0;
          cnt_d       = '0;
          // Flag a timeout only when the hold limit alone ended the grant.
          timeout_d   = hold_hit & ~rel & owner_req;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d     = StIdle;
        gnt_d       = 8'd0;
        gnt_id_d    = 3'd0;
        gnt_valid_d = 1'b0;
        cnt_d       = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      gnt_q       <= 8'd0;
      gnt_id_q    <= 3'd0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      cnt_q       <= '0;
      last_id_q   <= 3'd0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
      cnt_q       <= cnt_d;
      last_id_q   <= last_id_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;

endmodule
